operand_sequencer: RTL

Single-issue controller that sequences one dual-port field-element RAM (DATA-wide words, 2**ADDR deep, registered read, 1-cycle read latency on both ports) against an external arithmetic unit. It accepts {op, src0, src1, dst} commands over a valid/ready handshake. It reads both operands in the same cycle (src0 on port A, src1 on port B), runs the ALU via a start/done handshake, and writes the result back through port A. It sits between the top-level command source and the RAM/ALU pair.

---
 rtl/opseq_pkg.sv | 15 +
 rtl/operand_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/opseq_pkg.sv
// Shared definitions for the operand sequencer: FSM state encoding and opcode constants.
// OP_COPY only changes behaviour when the design is built with OPSEQ_COPY_EN.
package opseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam int OP_COPY = 0;

endpackage

// File: rtl/operand_sequencer.sv
// Single-issue sequencer: reads two RAM operands, runs the external ALU, writes the result back.
// Build option OPSEQ_COPY_EN turns opcode OP_COPY into a direct RAM-to-RAM move that bypasses the ALU.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DATA = 198,
  parameter int ADDR = 6,
  parameter int OPW  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [ADDR-1:0] cmd_src0,
  input  logic [ADDR-1:0] cmd_src1,
  input  logic [ADDR-1:0] cmd_dst,
  output logic            ram_a_wr,
  output logic [ADDR-1:0] ram_a_addr,
  output logic [DATA-1:0] ram_a_din,
  input  logic [DATA-1:0] ram_a_dout,
  output logic            ram_b_wr,
  output logic [ADDR-1:0] ram_b_addr,
  output logic [DATA-1:0] ram_b_din,
  input  logic [DATA-1:0] ram_b_dout,
  output logic            alu_start,
  output logic [OPW-1:0]  alu_op,
  output logic [DATA-1:0] alu_x,
  output logic [DATA-1:0] alu_y,
  input  logic            alu_done,
  input  logic [DATA-1:0] alu_result,
  output logic            busy,
  output logic            cmd_done,
  output state_t          dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so at most one command is ever in flight.

  state_t          r_state;
  state_t          w_next;
  logic [OPW-1:0]  r_op;
  logic [ADDR-1:0] r_src0;
  logic [ADDR-1:0] r_src1;
  logic [ADDR-1:0] r_dst;
  logic [DATA-1:0] r_alu_x;
  logic [DATA-1:0] r_alu_y;
  logic [DATA-1:0] r_result;
  logic            r_alu_start;
  logic            w_take_done;

  // r_alu_start marks the first EXEC cycle, where a done pulse is too early to be real.
  assign w_take_done = (r_state == ST_EXEC) && alu_done && !r_alu_start;

`ifdef OPSEQ_COPY_EN
  logic w_copy;
  assign w_copy = (r_op == OPW'(OP_COPY));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_src0      <= '0;
      r_src1      <= '0;
      r_dst       <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_result    <= '0;
      r_alu_start <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_alu_start <= 1'b0;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_op   <= cmd_op;
        r_src0 <= cmd_src0;
        r_src1 <= cmd_src1;
        r_dst  <= cmd_dst;
      end
      if (r_state == ST_LATCH) begin
        r_alu_x <= ram_a_dout;
        r_alu_y <= ram_b_dout;
`ifdef OPSEQ_COPY_EN
        if (w_copy) r_result <= ram_a_dout;
        else        r_alu_start <= 1'b1;
`else
        r_alu_start <= 1'b1;
`endif
      end
      if (w_take_done) r_result <= alu_result;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_next = ST_READ;
      ST_READ:  w_next = ST_LATCH;
`ifdef OPSEQ_COPY_EN
      ST_LATCH: w_next = w_copy ? ST_WRITE : ST_EXEC;
`else
      ST_LATCH: w_next = ST_EXEC;
`endif
      ST_EXEC:  if (w_take_done) w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_a_wr   = 1'b0;
    ram_a_addr = '0;
    ram_a_din  = '0;
    ram_b_addr = '0;
    case (r_state)
      ST_READ: begin
        ram_a_addr = r_src0;
        ram_b_addr = r_src1;
      end
      ST_WRITE: begin
        ram_a_wr   = 1'b1;
        ram_a_addr = r_dst;
        ram_a_din  = r_result;
      end
      default: ;
    endcase
  end

  assign ram_b_wr  = 1'b0;
  assign ram_b_din = '0;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign cmd_done  = (r_state == ST_WRITE);
  assign alu_start = r_alu_start;
  assign alu_op    = r_op;
  assign alu_x     = r_alu_x;
  assign alu_y     = r_alu_y;
  assign dbg_state = r_state;

endmodule
